// File: rtl/async_fifo_pkg.sv
// Shared helpers for the dual-clock FIFO: Gray/binary conversion and
// elaboration-time parameter rules.
package async_fifo_pkg;

  localparam int MAX_PTR_W = 32;

  // Width-generic by zero-extension: unused upper bits stay zero in both directions.
  function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
    logic [MAX_PTR_W-1:0] b;
    b = '0;
    b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit af_level_ok(input int af_level, input int depth);
    return (af_level >= 1) && (af_level <= depth);
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary decoder; each binary bit is the XOR of all
// Gray bits at or above it.
module gray2bin #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/async_wr_ctrl.sv
// Write-side pointer and flag controller of the dual-clock FIFO. Owns the
// Gray write pointer and derives registered full/almost-full/count status.
module async_wr_ctrl
  import async_fifo_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                          wr_clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [addr_width(DEPTH):0]    rd_ptr_wsync,
  output logic [addr_width(DEPTH)-1:0]  wr_addr,
  output logic [addr_width(DEPTH):0]    wr_ptr,
  output logic                          wr_full,
  output logic                          wr_almost_full,
  output logic [addr_width(DEPTH):0]    wr_count,
  output logic                          wr_ack,
  output logic                          wr_overflow
);

  localparam int AWIDTH = addr_width(DEPTH);
  localparam int PW     = AWIDTH + 1;

  if (!depth_ok(DEPTH) || !af_level_ok(AF_LEVEL, DEPTH)) begin : g_bad_params
    $error("async_wr_ctrl: DEPTH must be a power of two >= 2 and AF_LEVEL in 1..DEPTH");
  end

  logic [PW-1:0] wr_ptr_bin_q, wr_ptr_bin_d;
  logic [PW-1:0] wr_ptr_q,     wr_ptr_d;
  logic [PW-1:0] wr_count_q,   wr_count_d;
  logic          wr_full_q,    wr_full_d;
  logic          wr_af_q,      wr_af_d;
  logic          wr_ack_q,     wr_ack_d;
  logic          wr_ovf_q,     wr_ovf_d;

  logic          wr_accept;
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] cnt_nxt;

  gray2bin #(.WIDTH(PW)) u_rd_decode (
    .gray (rd_ptr_wsync),
    .bin  (rd_bin)
  );

  // The extra pointer MSB lets a plain wrapped subtraction tell full from empty.
  always_comb begin
    wr_accept    = wr_en & ~wr_full_q;
    wr_ptr_bin_d = wr_ptr_bin_q + {{AWIDTH{1'b0}}, wr_accept};
    wr_ptr_d     = PW'(bin2gray(MAX_PTR_W'(wr_ptr_bin_d)));
    cnt_nxt      = wr_ptr_bin_d - rd_bin;
    wr_count_d   = cnt_nxt;
    wr_full_d    = (cnt_nxt == PW'(DEPTH));
    wr_af_d      = (cnt_nxt >= PW'(AF_LEVEL));
    wr_ack_d     = wr_accept;
    wr_ovf_d     = wr_ovf_q | (wr_en & wr_full_q);
  end

  always_ff @(posedge wr_clk) begin
    if (!rst_n) begin
      wr_ptr_bin_q <= '0;
      wr_ptr_q     <= '0;
      wr_count_q   <= '0;
      wr_full_q    <= 1'b0;
      wr_af_q      <= 1'b0;
      wr_ack_q     <= 1'b0;
      wr_ovf_q     <= 1'b0;
    end else begin
      wr_ptr_bin_q <= wr_ptr_bin_d;
      wr_ptr_q     <= wr_ptr_d;
      wr_count_q   <= wr_count_d;
      wr_full_q    <= wr_full_d;
      wr_af_q      <= wr_af_d;
      wr_ack_q     <= wr_ack_d;
      wr_ovf_q     <= wr_ovf_d;
    end
  end

  assign wr_addr        = wr_ptr_bin_q[AWIDTH-1:0];
  assign wr_ptr         = wr_ptr_q;
  assign wr_full        = wr_full_q;
  assign wr_almost_full = wr_af_q;
  assign wr_count       = wr_count_q;
  assign wr_ack         = wr_ack_q;
  assign wr_overflow    = wr_ovf_q;

endmodule

// File: tb/tb_async_wr_ctrl.sv
// Bench for async_wr_ctrl: directed scenarios plus random traffic, checked
// against a model that tracks total writes and reads as plain integers.
module tb_async_wr_ctrl;

  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AW    = 2;
  localparam int PW    = 3;

  logic          wr_clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [PW-1:0] rd_ptr_wsync;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wr_ptr;
  logic          wr_full;
  logic          wr_almost_full;
  logic [PW-1:0] wr_count;
  logic          wr_ack;
  logic          wr_overflow;

  async_wr_ctrl #(.DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .wr_clk         (wr_clk),
    .rst_n          (rst_n),
    .wr_en          (wr_en),
    .rd_ptr_wsync   (rd_ptr_wsync),
    .wr_addr        (wr_addr),
    .wr_ptr         (wr_ptr),
    .wr_full        (wr_full),
    .wr_almost_full (wr_almost_full),
    .wr_count       (wr_count),
    .wr_ack         (wr_ack),
    .wr_overflow    (wr_overflow)
  );

  // Clock
  always #5 wr_clk = ~wr_clk;

  // Model: occupancy is simply writes accepted minus reads seen.
  int   tests = 0;
  int   fails = 0;
  int   m_wr  = 0;
  int   m_rd  = 0;
  int   m_cnt = 0;
  logic m_full = 1'b0;
  logic m_af   = 1'b0;
  logic m_ack  = 1'b0;
  logic m_ovf  = 1'b0;
  int   full_seen_in_wrap = 0;
  logic [AW-1:0] exp_q[$];

  function automatic logic [PW-1:0] gray_of(input int n);
    logic [PW-1:0] b;
    b = PW'(n % (2 * DEPTH));
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle: write request, absolute read count, reset.
  task automatic step(input logic we, input int rd, input logic rst);
    logic acc;
    @(negedge wr_clk);
    rst_n        = ~rst;
    wr_en        = we;
    rd_ptr_wsync = gray_of(rd);
    acc = !rst && we && !m_full;
    if (acc) begin
      exp_q.push_back(AW'(m_wr % DEPTH));
      #1;
      check("wr_addr_at_write", 32'(wr_addr), 32'(exp_q.pop_front()));
    end
    @(posedge wr_clk);
    if (rst) begin
      m_wr = 0; m_rd = 0; m_cnt = 0;
      m_full = 1'b0; m_af = 1'b0; m_ack = 1'b0; m_ovf = 1'b0;
    end else begin
      m_ovf  = m_ovf | (we & m_full);
      if (acc) m_wr++;
      m_rd   = rd;
      m_cnt  = m_wr - m_rd;
      m_full = (m_cnt == DEPTH);
      m_af   = (m_cnt >= AF);
      m_ack  = acc;
    end
    #1;
    check("wr_ptr",         32'(wr_ptr),         32'(gray_of(m_wr)));
    check("wr_addr",        32'(wr_addr),        32'(m_wr % DEPTH));
    check("wr_count",       32'(wr_count),       32'(m_cnt));
    check("wr_full",        32'(wr_full),        32'(m_full));
    check("wr_almost_full", 32'(wr_almost_full), 32'(m_af));
    check("wr_ack",         32'(wr_ack),         32'(m_ack));
    check("wr_overflow",    32'(wr_overflow),    32'(m_ovf));
  endtask

  initial begin
    rst_n        = 1'b0;
    wr_en        = 1'b0;
    rd_ptr_wsync = '0;

    // Reset held 3 cycles with wr_en high
    for (int i = 0; i < 3; i++) step(1'b1, 0, 1'b1);
    check("reset_ptr_zero", 32'(wr_ptr), 32'(0));

    // Fill to full with no reads
    for (int i = 0; i < 4; i++) step(1'b1, 0, 1'b0);
    check("fill_ptr_110", 32'(wr_ptr), 32'(3'b110));
    check("fill_full", 32'(wr_full), 32'(1));

    // Overflow: two dropped writes
    for (int i = 0; i < 2; i++) step(1'b1, 0, 1'b0);
    check("ovf_ptr_held", 32'(wr_ptr), 32'(3'b110));
    check("ovf_sticky", 32'(wr_overflow), 32'(1));

    // Release: one read, then a write lands at address 0
    step(1'b0, 1, 1'b0);
    check("release_count", 32'(wr_count), 32'(3));
    step(1'b1, 1, 1'b0);

    // Reset mid-operation clears everything including overflow
    step(1'b0, 2, 1'b0);
    step(1'b1, 2, 1'b1);
    check("midreset_ovf", 32'(wr_overflow), 32'(0));
    check("midreset_count", 32'(wr_count), 32'(0));

    // Wrap: occupancy pinned at 2 while pointers circle
    step(1'b1, 0, 1'b0);
    step(1'b1, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, m_wr - 1, 1'b0);
      if (wr_full) full_seen_in_wrap++;
    end
    check("wrap_count_2", 32'(wr_count), 32'(2));
    check("wrap_never_full", 32'(full_seen_in_wrap), 32'(0));

    // Random traffic; reads never pass writes already committed
    for (int i = 0; i < 400; i++) begin
      logic we;
      int   rd;
      we = ($urandom_range(0, 3) != 0);
      rd = m_rd + $urandom_range(0, m_wr - m_rd);
      if ($urandom_range(0, 2) == 0) rd = m_rd;
      step(we, rd, ($urandom_range(0, 99) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
